// File: rtl/tiny1_irq_ctl.sv
// tiny1_irq_ctl: memory-mapped interrupt controller driving the tiny1 core irq/irqack handshake
module tiny1_irq_ctl #(
    parameter int              NSRC      = 8,
    parameter logic [15:0]     BASE_ADDR = 16'h4000,
    parameter logic [NSRC-1:0] EDGE_RST  = {NSRC{1'b1}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    output logic            irq,
    input  logic            irqack,
    input  logic [15:0]     mem_addr,
    input  logic [15:0]     mem_wdata,
    input  logic            mem_wr,
    input  logic            mem_rd,
    output logic [15:0]     rd_data,
    output logic            rd_hit
);
    typedef enum logic [1:0] {IDLE, REQ, ACTIVE, WAITLOW} state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] pend_q, pend_d, mask_q, mask_d, edge_q, edge_d, src_q;
    logic [NSRC-1:0] elig, win_oh, clr;
    logic [15:0]     vec_q, vec_d, rd_mux, rd_data_q;
    logic [3:0]      win;
    logic            irq_q, rd_hit_q, hit, wr_hit, latch;
    logic [2:0]      off;
    logic            unused_wdata;

    assign hit          = mem_addr[15:3] == BASE_ADDR[15:3];
    assign off          = mem_addr[2:0];
    assign wr_hit       = mem_wr & hit;
    assign elig         = pend_q & mask_q;
    assign unused_wdata = ^mem_wdata;
    assign irq          = irq_q;
    assign rd_hit       = rd_hit_q;
    assign rd_data      = rd_data_q;

    // priority encoder: the lowest eligible index wins
    always_comb begin
        win    = 4'd0;
        win_oh = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win       = 4'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    // handshake FSM next state; the vector is captured when the core acknowledges
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        vec_d   = vec_q;
        case (state_q)
            IDLE:    if (|elig) state_d = REQ;
            REQ: begin
                if (irqack) begin
                    latch   = 1'b1;
                    vec_d   = (|elig) ? 16'(win) : 16'h800F;
                    state_d = ACTIVE;
                end else if (~|elig) begin
                    state_d = IDLE;
                end
            end
            ACTIVE:  if (!irqack) state_d = WAITLOW;
            WAITLOW: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // pending/mask/edge next state; level-mode bits simply follow their source
    always_comb begin
        clr    = ((wr_hit && off == 3'd0) ? mem_wdata[NSRC-1:0] : '0) | (latch ? (win_oh & edge_q) : '0);
        pend_d = (edge_q & ((pend_q & ~clr) | (src & ~src_q))) | (~edge_q & src);
        mask_d = (wr_hit && off == 3'd1) ? mem_wdata[NSRC-1:0] : mask_q;
        edge_d = (wr_hit && off == 3'd2) ? mem_wdata[NSRC-1:0] : edge_q;
    end

    // register read mux, sampled into the one-cycle read pipeline
    always_comb begin
        rd_mux = '0;
        case (off)
            3'd0:    rd_mux = 16'(pend_q);
            3'd1:    rd_mux = 16'(mask_q);
            3'd2:    rd_mux = 16'(edge_q);
            3'd3:    rd_mux = vec_q;
            3'd4:    rd_mux = {14'd0, (state_q == ACTIVE) || (state_q == WAITLOW), irq_q};
            default: rd_mux = '0;
        endcase
    end

    // all state, cleared asynchronously so a reset mid-handler drops irq at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            irq_q     <= 1'b0;
            rd_hit_q  <= 1'b0;
            rd_data_q <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            edge_q    <= EDGE_RST;
            vec_q     <= '0;
            src_q     <= '0;
        end else begin
            state_q   <= state_d;
            irq_q     <= state_d == REQ;
            rd_hit_q  <= mem_rd & hit;
            rd_data_q <= rd_mux;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            edge_q    <= edge_d;
            vec_q     <= vec_d;
            src_q     <= src;
        end
    end
endmodule

// File: tb/tb_tiny1_irq_ctl.sv
// tb_tiny1_irq_ctl: directed plus random checks of tiny1_irq_ctl against a behavioural model
module tb_tiny1_irq_ctl;
    localparam int          N    = 8;
    localparam logic [15:0] BASE = 16'h4000;

    logic          clk = 1'b0, rst = 1'b0, irqack = 1'b0, mem_wr = 1'b0, mem_rd = 1'b0;
    logic [N-1:0]  src = '0;
    logic [15:0]   mem_addr = '0, mem_wdata = '0;
    logic          irq, rd_hit;
    logic [15:0]   rd_data;
    int            tests = 0, fails = 0;

    // model: pending/mask/edge words, handler phase flags, read pipeline
    logic [N-1:0]  m_pend, m_mask, m_edge, m_srcq;
    logic [15:0]   m_vec, m_rddata;
    logic          m_req, m_svc, m_wl, m_rdhit;

    always #5 clk = ~clk;

    tiny1_irq_ctl #(.NSRC(N), .BASE_ADDR(BASE), .EDGE_RST(8'hFF)) dut (
        .clk(clk), .rst(rst), .src(src), .irq(irq), .irqack(irqack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .rd_data(rd_data), .rd_hit(rd_hit)
    );

    function automatic logic [15:0] r(input int o);
        return BASE + 16'(o);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_edge = 8'hFF; m_srcq = '0; m_vec = '0;
        m_rddata = '0; m_req = 0; m_svc = 0; m_wl = 0; m_rdhit = 0;
    endtask

    // one clock: predict from the spec rules, advance, then compare outputs
    task automatic cyc();
        logic [N-1:0] el, clr, pn;
        logic [15:0]  rdn, vn;
        logic         rq, sv, wl, h;
        logic [2:0]   o;
        int           w;
        h  = mem_addr[15:3] == BASE[15:3];
        o  = mem_addr[2:0];
        el = m_pend & m_mask;
        w  = -1;
        for (int i = 0; i < N; i++) if (el[i] && w < 0) w = i;
        case (o)
            3'd0:    rdn = {8'h00, m_pend};
            3'd1:    rdn = {8'h00, m_mask};
            3'd2:    rdn = {8'h00, m_edge};
            3'd3:    rdn = m_vec;
            3'd4:    rdn = {14'd0, m_svc | m_wl, m_req};
            default: rdn = 16'h0000;
        endcase
        clr = (mem_wr && h && o == 3'd0) ? mem_wdata[N-1:0] : '0;
        rq = m_req; sv = m_svc; wl = m_wl; vn = m_vec;
        if (!m_req && !m_svc && !m_wl) rq = el != 0;
        else if (m_req) begin
            if (irqack) begin
                rq = 0; sv = 1;
                if (w >= 0) begin vn = 16'(w); if (m_edge[w]) clr[w] = 1'b1; end
                else vn = 16'h800F;
            end else if (el == 0) rq = 0;
        end else if (m_svc) begin
            if (!irqack) begin sv = 0; wl = 1; end
        end else wl = 0;
        for (int i = 0; i < N; i++)
            pn[i] = m_edge[i] ? ((m_pend[i] & ~clr[i]) | (src[i] & ~m_srcq[i])) : src[i];
        @(posedge clk);
        #1;
        if (mem_wr && h && o == 3'd1) m_mask = mem_wdata[N-1:0];
        if (mem_wr && h && o == 3'd2) m_edge = mem_wdata[N-1:0];
        m_pend = pn; m_srcq = src; m_vec = vn;
        m_req = rq; m_svc = sv; m_wl = wl;
        m_rdhit = mem_rd && h; m_rddata = rdn;
        chk("irq", 16'(irq), 16'(m_req));
        chk("rd_hit", 16'(rd_hit), 16'(m_rdhit));
        if (m_rdhit) chk("rd_data", rd_data, m_rddata);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        mem_wr = 1; mem_addr = a; mem_wdata = d;
        cyc();
        mem_wr = 0;
    endtask

    task automatic rd(input logic [15:0] a);
        mem_rd = 1; mem_addr = a;
        cyc();
        mem_rd = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_irq", 16'(irq), 16'h0);
        chk("reset_rdhit", 16'(rd_hit), 16'h0);
        chk("reset_rddata", rd_data, 16'h0);
        @(negedge clk);
        rst = 1;
        // single edge-mode source
        rd(r(2));  chk("edge_rst", rd_data, 16'h00FF);
        wr(r(1), 16'h0001);
        wr(r(2), 16'h0001);
        src = 8'h01; cyc(); src = 8'h00; cyc();
        chk("t1_irq", 16'(irq), 16'h1);
        rd(r(0));  chk("t1_pend", rd_data, 16'h0001);
        irqack = 1; cyc(); chk("t1_irq_ack", 16'(irq), 16'h0);
        irqack = 0;
        rd(r(3));  chk("t1_vec", rd_data, 16'h0000);
        rd(r(0));  chk("t1_pend_clr", rd_data, 16'h0000);
        // two sources at once, priority order
        wr(r(1), 16'h00FF);
        wr(r(2), 16'h00FF);
        src = 8'h24; cyc(); src = 8'h00; cyc();
        irqack = 1; cyc(); irqack = 0;
        rd(r(3));  chk("t2_vec_a", rd_data, 16'h0002);
        cyc(); cyc();
        chk("t2_irq_again", 16'(irq), 16'h1);
        irqack = 1; cyc();
        rd(r(4));  chk("t2_status", rd_data, 16'h0002);
        irqack = 0;
        rd(r(3));  chk("t2_vec_b", rd_data, 16'h0005);
        cyc();
        // level mode follows the source
        wr(r(2), 16'h0000);
        src = 8'h08; cyc(); cyc();
        irqack = 1; cyc(); irqack = 0; cyc(); cyc(); cyc();
        chk("t3_irq_level", 16'(irq), 16'h1);
        src = 8'h00; cyc();
        rd(r(0));  chk("t3_pend", rd_data, 16'h0000);
        chk("t3_irq_drop", 16'(irq), 16'h0);
        repeat (3) cyc();
        // masking in REQ, then mask racing the ack
        wr(r(2), 16'h00FF);
        src = 8'h02; cyc(); src = 8'h00; cyc();
        chk("t4_irq", 16'(irq), 16'h1);
        wr(r(1), 16'h0000); cyc();
        chk("t4_irq_masked", 16'(irq), 16'h0);
        wr(r(1), 16'h00FF); cyc();
        chk("t4_irq_re", 16'(irq), 16'h1);
        wr(r(1), 16'h0000);
        irqack = 1; cyc(); irqack = 0;
        rd(r(3));  chk("t4_spurious", rd_data, 16'h800F);
        cyc();
        wr(r(0), 16'h00FF);
        // W1C loses to a simultaneous rising edge
        src = 8'h00; cyc();
        src = 8'h04; wr(r(0), 16'h0004); src = 8'h00;
        rd(r(0));  chk("t5_w1c", rd_data, 16'h0004);
        wr(r(1), 16'h005A);
        rd(r(1));  chk("t5_rdhit", 16'(rd_hit), 16'h1); chk("t5_mask", rd_data, 16'h005A);
        cyc();     chk("t5_rdhit_once", 16'(rd_hit), 16'h0);
        rd(BASE + 16'd8); chk("t5_miss", 16'(rd_hit), 16'h0);
        // asynchronous reset mid-handler
        wr(r(1), 16'h00FF); cyc();
        irqack = 1; cyc();
        mem_rd = 1; mem_addr = r(2); cyc();
        #2 rst = 0;
        #1;
        chk("t6_irq", 16'(irq), 16'h0);
        chk("t6_rdhit", 16'(rd_hit), 16'h0);
        chk("t6_rddata", rd_data, 16'h0);
        chk("t6_pend", 16'(dut.pend_q), 16'h0);
        chk("t6_edge", 16'(dut.edge_q), 16'h00FF);
        irqack = 0; mem_rd = 0;
        model_reset();
        @(negedge clk);
        rst = 1;
        rd(r(0));  chk("t6_pend_rd", rd_data, 16'h0000);
        // random traffic
        for (int k = 0; k < 600; k++) begin
            src = 8'($urandom);
            if (m_req) irqack = ($urandom_range(0, 1) == 1);
            else if (m_svc) irqack = ($urandom_range(0, 3) != 0);
            else irqack = ($urandom_range(0, 15) == 0);
            mem_rd = ($urandom_range(0, 3) != 0);
            mem_wr = ($urandom_range(0, 3) == 0);
            mem_addr = ($urandom_range(0, 4) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 9));
            mem_wdata = 16'($urandom);
            cyc();
        end
        mem_rd = 0; mem_wr = 0; irqack = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
